// File: rtl/svutest_req_rsp_responder.sv
`default_nettype none
// ============================================================================
// Module   : svutest_req_rsp_responder
// Purpose  : Target-side req/rsp responder with payload FIFO, protocol
//            checker and transfer-count done flag.
//            Optional LFSR backpressure: SVUTEST_RESPONDER_RANDOM_STALL_EN
// Revision : 1.0 - initial release
// ============================================================================
module svutest_req_rsp_responder #(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned DEPTH    = 4,
    parameter int unsigned EXPECTED = 16,
    parameter logic [15:0] SEED     = 16'hACE1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       req,
    input  logic [WIDTH-1:0]           req_payload,
    output logic                       rsp,
    input  logic                       stall,
    output logic                       out_valid,
    output logic [WIDTH-1:0]           out_payload,
    input  logic                       pop,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic [31:0]                accepted,
    output logic                       protocol_error,
    output logic                       done
);

    localparam int unsigned c_CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned c_PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [c_CNT_W-1:0] c_DEPTH_CNT = c_CNT_W'(DEPTH);
    localparam logic [c_PTR_W-1:0] c_LAST_PTR  = c_PTR_W'(DEPTH - 1);
    localparam logic [15:0]        c_SEED      = (SEED == 16'h0000) ? 16'hACE1 : SEED;

    logic [WIDTH-1:0]   mem_q [DEPTH];
    logic [c_PTR_W-1:0] head_q, head_d;
    logic [c_PTR_W-1:0] tail_q, tail_d;
    logic [c_CNT_W-1:0] count_q, count_d;
    logic [31:0]        accepted_q, accepted_d;
    logic               perr_q, perr_d;
    logic               done_q, done_d;
    logic               hist_req_q, hist_req_d;
    logic               hist_rsp_q, hist_rsp_d;
    logic [WIDTH-1:0]   hist_payload_q, hist_payload_d;

    logic rand_stall;
    logic push;
    logic do_pop;
    logic violation;

    function automatic logic [c_PTR_W-1:0] next_ptr(input logic [c_PTR_W-1:0] p);
        return (p == c_LAST_PTR) ? '0 : p + 1'b1;
    endfunction

`ifdef SVUTEST_RESPONDER_RANDOM_STALL_EN
    logic [15:0] lfsr_q, lfsr_d;
    logic        lfsr_fb;

    // Right-shifting Fibonacci form of taps 16,14,13,11
    always_comb begin
        lfsr_fb = lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5];
        lfsr_d  = {lfsr_fb, lfsr_q[15:1]};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lfsr_q <= c_SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign rand_stall = (lfsr_q[1:0] == 2'b00);
`else
    logic unused_seed;
    assign unused_seed = ^c_SEED;
    assign rand_stall  = 1'b0;
`endif

    // Acceptance looks at pre-pop occupancy, so a full FIFO never pushes
    // in the same cycle it pops.
    assign rsp    = rst && (count_q < c_DEPTH_CNT) && !stall && !rand_stall;
    assign push   = req && rsp;
    assign do_pop = pop && out_valid;

    assign violation = hist_req_q && !hist_rsp_q &&
                       (!req || (req_payload != hist_payload_q));

    always_comb begin
        head_d         = head_q;
        tail_d         = tail_q;
        count_d        = count_q;
        accepted_d     = accepted_q;
        perr_d         = perr_q | violation;
        hist_req_d     = req;
        hist_rsp_d     = rsp;
        hist_payload_d = req_payload;
        done_d         = (EXPECTED != 0) && (accepted_q >= EXPECTED) && (count_q == '0);

        if (push) begin
            tail_d = next_ptr(tail_q);
            if (accepted_q != 32'hFFFF_FFFF) begin
                accepted_d = accepted_q + 32'd1;
            end
        end
        if (do_pop) begin
            head_d = next_ptr(head_q);
        end
        if (push && !do_pop) begin
            count_d = count_q + 1'b1;
        end else if (!push && do_pop) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head_q         <= '0;
            tail_q         <= '0;
            count_q        <= '0;
            accepted_q     <= '0;
            perr_q         <= 1'b0;
            done_q         <= 1'b0;
            hist_req_q     <= 1'b0;
            hist_rsp_q     <= 1'b0;
            hist_payload_q <= '0;
        end else begin
            head_q         <= head_d;
            tail_q         <= tail_d;
            count_q        <= count_d;
            accepted_q     <= accepted_d;
            perr_q         <= perr_d;
            done_q         <= done_d;
            hist_req_q     <= hist_req_d;
            hist_rsp_q     <= hist_rsp_d;
            hist_payload_q <= hist_payload_d;
        end
    end

    // Storage needs no reset; the read port is masked while empty.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[tail_q] <= req_payload;
        end
    end

    assign out_valid      = (count_q != '0);
    assign out_payload    = out_valid ? mem_q[head_q] : '0;
    assign count          = count_q;
    assign accepted       = accepted_q;
    assign protocol_error = perr_q;
    assign done           = done_q;

endmodule
`default_nettype wire

// File: tb/tb_svutest_req_rsp_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_svutest_req_rsp_responder
// Purpose  : Directed bench with a queue-based reference model of the responder.
// Revision : 1.0 - initial release
// ============================================================================
module tb_svutest_req_rsp_responder;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned EXP_A = 2;
    localparam logic [15:0] SEED  = 16'hACE1;
`ifdef SVUTEST_RESPONDER_RANDOM_STALL_EN
    localparam int N_STREAM = 1000;
`else
    localparam int N_STREAM = 40;
`endif

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             req = 1'b0;
    logic             stall = 1'b0;
    logic             pop = 1'b0;
    logic [WIDTH-1:0] req_payload = '0;

    logic             a_rsp, a_valid, a_perr, a_done;
    logic [WIDTH-1:0] a_payload;
    logic [2:0]       a_count;
    logic [31:0]      a_acc;
    logic             b_rsp, b_valid, b_perr, b_done;
    logic [WIDTH-1:0] b_payload;
    logic [2:0]       b_count;
    logic [31:0]      b_acc;

    svutest_req_rsp_responder #(.WIDTH(WIDTH), .DEPTH(DEPTH), .EXPECTED(EXP_A), .SEED(SEED)) u_dut_a (
        .clk(clk), .rst(rst), .req(req), .req_payload(req_payload), .rsp(a_rsp),
        .stall(stall), .out_valid(a_valid), .out_payload(a_payload), .pop(pop),
        .count(a_count), .accepted(a_acc), .protocol_error(a_perr), .done(a_done));

    svutest_req_rsp_responder #(.WIDTH(WIDTH), .DEPTH(DEPTH), .EXPECTED(0), .SEED(SEED)) u_dut_b (
        .clk(clk), .rst(rst), .req(req), .req_payload(req_payload), .rsp(b_rsp),
        .stall(stall), .out_valid(b_valid), .out_payload(b_payload), .pop(pop),
        .count(b_count), .accepted(b_acc), .protocol_error(b_perr), .done(b_done));

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model state
    logic [WIDTH-1:0] mq[$];
    int unsigned      m_acc  = 0;
    bit               m_perr = 0;
    bit               m_done = 0;
    bit               h_req  = 0;
    bit               h_rsp  = 0;
    logic [WIDTH-1:0] h_pay  = '0;
    logic [15:0]      m_lfsr = SEED;

    function automatic bit m_rand_stall();
`ifdef SVUTEST_RESPONDER_RANDOM_STALL_EN
        return (m_lfsr[1:0] == 2'b00);
`else
        return 1'b0;
`endif
    endfunction

    function automatic bit m_rsp();
        return rst && (mq.size() < DEPTH) && !stall && !m_rand_stall();
    endfunction

    // Compare mid-cycle, advance the model at the rising edge
    initial begin
        bit               r;
        bit               nd;
        logic [WIDTH-1:0] junk;
        forever begin
            @(negedge clk);
            if (!rst) begin
                chk("m_rst_rsp", {31'd0, a_rsp}, 32'd0);
                chk("m_rst_count", {29'd0, a_count}, 32'd0);
                chk("m_rst_valid", {31'd0, a_valid}, 32'd0);
                chk("m_rst_acc", a_acc, 32'd0);
                chk("m_rst_perr", {31'd0, a_perr}, 32'd0);
                chk("m_rst_done", {31'd0, a_done}, 32'd0);
            end else begin
                chk("m_rsp", {31'd0, a_rsp}, {31'd0, m_rsp()});
                chk("m_count", {29'd0, a_count}, mq.size());
                chk("m_valid", {31'd0, a_valid}, {31'd0, mq.size() > 0});
                if (mq.size() > 0) chk("m_payload", {24'd0, a_payload}, {24'd0, mq[0]});
                chk("m_acc", a_acc, m_acc);
                chk("m_perr", {31'd0, a_perr}, {31'd0, m_perr});
                chk("m_done", {31'd0, a_done}, {31'd0, m_done});
                chk("m_b_done", {31'd0, b_done}, 32'd0);
                chk("m_b_count", {29'd0, b_count}, mq.size());
            end
            @(posedge clk);
            if (!rst) begin
                mq.delete();
                m_acc = 0; m_perr = 0; m_done = 0;
                h_req = 0; h_rsp = 0; h_pay = '0;
                m_lfsr = SEED;
            end else begin
                r  = m_rsp();
                nd = (EXP_A != 0) && (m_acc >= EXP_A) && (mq.size() == 0);
                if (h_req && !h_rsp && (!req || req_payload !== h_pay)) m_perr = 1;
                if (pop && mq.size() > 0) junk = mq.pop_front();
                if (req && r) begin
                    mq.push_back(req_payload);
                    if (m_acc != 32'hFFFF_FFFF) m_acc++;
                end
                m_done = nd;
                h_req = req; h_rsp = r; h_pay = req_payload;
                m_lfsr = {m_lfsr[0] ^ m_lfsr[2] ^ m_lfsr[3] ^ m_lfsr[5], m_lfsr[15:1]};
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit r, input logic [WIDTH-1:0] p, input bit po, input bit st);
        req = r; req_payload = p; pop = po; stall = st;
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        drive(0, 8'h00, 0, 0);
        tick();
        tick();
        rst = 1'b1;
    endtask

    initial begin
        logic [WIDTH-1:0] heads[4];
        logic [WIDTH-1:0] pay;
        int               n_rsp;

        // Reset values
        drive(1, 8'hEE, 0, 0);
        chk("reset_rsp", {31'd0, a_rsp}, 32'd0);
        tick();
        chk("reset_count", {29'd0, a_count}, 32'd0);
        chk("reset_valid", {31'd0, a_valid}, 32'd0);
        chk("reset_payload", {24'd0, a_payload}, 32'd0);
        chk("reset_acc", a_acc, 32'd0);
        chk("reset_perr", {31'd0, a_perr}, 32'd0);
        chk("reset_done", {31'd0, a_done}, 32'd0);
        drive(0, 8'h00, 0, 0);
        tick();
        rst = 1'b1;

        // Basic flow
        drive(1, 8'h11, 0, 0); chk("basic_rsp1", {31'd0, a_rsp}, 32'd1); tick();
        drive(1, 8'h22, 0, 0); chk("basic_rsp2", {31'd0, a_rsp}, 32'd1); tick();
        drive(1, 8'h33, 0, 0); chk("basic_rsp3", {31'd0, a_rsp}, 32'd1); tick();
        drive(0, 8'h00, 0, 0);
        chk("basic_count", {29'd0, a_count}, 32'd3);
        chk("basic_head", {24'd0, a_payload}, 32'h11);
        chk("basic_acc", a_acc, 32'd3);
        chk("basic_done_pending", {31'd0, a_done}, 32'd0);

        // Full boundary
        drive(1, 8'h44, 0, 0); chk("full_rsp4", {31'd0, a_rsp}, 32'd1); tick();
        drive(1, 8'h55, 0, 0); chk("full_rsp5", {31'd0, a_rsp}, 32'd0); tick();
        chk("full_count", {29'd0, a_count}, 32'd4);
        drive(1, 8'h55, 1, 0); chk("full_pop_rsp", {31'd0, a_rsp}, 32'd0); tick();
        chk("full_pop_count", {29'd0, a_count}, 32'd3);
        chk("full_pop_head", {24'd0, a_payload}, 32'h22);
        drive(1, 8'h55, 0, 0); chk("full_resume_rsp", {31'd0, a_rsp}, 32'd1); tick();
        chk("full_resume_count", {29'd0, a_count}, 32'd4);
        chk("full_no_perr", {31'd0, a_perr}, 32'd0);
        heads[0] = 8'h22; heads[1] = 8'h33; heads[2] = 8'h44; heads[3] = 8'h55;
        for (int i = 0; i < 4; i++) begin
            drive(0, 8'h00, 1, 0);
            chk("drain_order", {24'd0, a_payload}, {24'd0, heads[i]});
            tick();
        end
        drive(0, 8'h00, 0, 0);
        chk("drain_empty", {31'd0, a_valid}, 32'd0);

        // Done
        do_reset();
        drive(1, 8'hAA, 0, 0); tick();
        drive(1, 8'hBB, 0, 0); tick();
        drive(0, 8'h00, 1, 0);
        chk("done_full2", {31'd0, a_done}, 32'd0);
        tick();
        chk("done_count1", {31'd0, a_done}, 32'd0);
        tick();
        drive(0, 8'h00, 0, 0);
        chk("done_count0_same", {31'd0, a_done}, 32'd0);
        tick();
        chk("done_set", {31'd0, a_done}, 32'd1);
        chk("done_exp0", {31'd0, b_done}, 32'd0);
        drive(1, 8'hCC, 0, 0); tick();
        drive(0, 8'h00, 0, 0);
        chk("done_still_1", {31'd0, a_done}, 32'd1);
        tick();
        chk("done_cleared", {31'd0, a_done}, 32'd0);

        // Protocol error: payload change
        do_reset();
        drive(1, 8'hA5, 0, 1); chk("perr1_rsp", {31'd0, a_rsp}, 32'd0); tick();
        drive(1, 8'h5A, 0, 1);
        chk("perr1_before", {31'd0, a_perr}, 32'd0);
        tick();
        chk("perr1_set", {31'd0, a_perr}, 32'd1);
        drive(0, 8'h00, 0, 0); tick(); tick();
        chk("perr1_sticky", {31'd0, a_perr}, 32'd1);

        // Protocol error: req drop
        do_reset();
        drive(1, 8'hA5, 0, 1); tick();
        drive(0, 8'hA5, 0, 1); tick();
        chk("perr2_set", {31'd0, a_perr}, 32'd1);

        // Stable payload under stall
        do_reset();
        drive(1, 8'hA5, 0, 1); tick(); tick(); tick();
        drive(1, 8'hA5, 0, 0); tick();
        drive(0, 8'h00, 0, 0); tick();
        chk("perr3_clear", {31'd0, a_perr}, 32'd0);
        chk("perr3_acc", a_acc, 32'd1);
        chk("perr3_head", {24'd0, a_payload}, 32'hA5);

        // Asynchronous reset mid-operation
        do_reset();
        drive(1, 8'hC1, 0, 0); tick();
        drive(1, 8'hC2, 0, 0); tick();
        drive(1, 8'hC3, 0, 0); tick();
        drive(1, 8'h77, 0, 1); tick();
        drive(1, 8'h78, 0, 1); tick();
        chk("mid_pre_count", {29'd0, a_count}, 32'd3);
        chk("mid_pre_perr", {31'd0, a_perr}, 32'd1);
        rst = 1'b0; stall = 1'b0;
        #1;
        chk("mid_rsp", {31'd0, a_rsp}, 32'd0);
        chk("mid_count", {29'd0, a_count}, 32'd0);
        chk("mid_acc", a_acc, 32'd0);
        chk("mid_perr", {31'd0, a_perr}, 32'd0);
        chk("mid_valid", {31'd0, a_valid}, 32'd0);
        drive(0, 8'h00, 0, 0);
        tick();
        rst = 1'b1;

        // Streaming with req and pop held high
        do_reset();
        pay   = 8'h01;
        n_rsp = 0;
        for (int i = 0; i < N_STREAM; i++) begin
            drive(1, pay, 1, (i % 7) == 5);
            if (a_rsp) begin
                pay = pay + 8'd1;
                n_rsp++;
            end
            tick();
        end
        drive(0, 8'h00, 0, 0);
        chk("stream_acc", a_acc, n_rsp);
        chk("stream_perr", {31'd0, a_perr}, 32'd0);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/svutest_req_rsp_responder.md
# svutest_req_rsp_responder

Target-side responder for the request/payload/response handshake used by svutest benches. It accepts requests into a FIFO of depth DEPTH and returns `rsp` as the per-cycle acceptance strobe. It exposes buffered payloads to the bench through a pop port and checks the initiator for handshake violations. It raises `done` after a programmed number of transfers, so it can drive a DUT-control `done` line directly.

## Interface
Parameters:
- `WIDTH`, 8: payload width in bits.
- `DEPTH`, 4: FIFO entries; legal range 1..256.
- `EXPECTED`, 16: transfer count that arms `done`; 0 disables `done`.
- `SEED`, 16'hACE1: LFSR seed; a value of 0 is replaced by 16'hACE1. Used only when the configuration macro is defined.

Ports:
- `clk`, input, 1: the single clock for the block; all state updates on its rising edge.
- `rst`, input, 1: reset, asynchronous and active-low (0 = reset asserted).
- `req`, input, 1: request from the initiator.
- `req_payload`, input, WIDTH: payload qualified by `req`.
- `rsp`, output, 1: acceptance strobe. A transfer completes in a cycle where `req && rsp`.
- `stall`, input, 1: bench-forced backpressure; holds `rsp` low.
- `out_valid`, output, 1: FIFO non-empty.
- `out_payload`, output, WIDTH: head-of-FIFO payload; valid while `out_valid`.
- `pop`, input, 1: removes the head entry when `out_valid`.
- `count`, output, $clog2(DEPTH+1): FIFO occupancy.
- `accepted`, output, 32: total completed transfers since reset.
- `protocol_error`, output, 1: sticky handshake-violation flag.
- `done`, output, 1: expected transfers reached and FIFO drained.

## Operation
- `rsp` is combinational: `rsp = rst && (count < DEPTH) && !stall && !rand_stall`. Without the macro, `rand_stall` is 0.
- Push: when `req && rsp`, `req_payload` is written at the tail, and `accepted` increments and saturates at 2^32-1.
- Pop: when `pop && out_valid`, the head is removed. A `pop` while empty is ignored and is not an error.
- Simultaneous push and pop: `count` is unchanged and both pointers advance.
- Full with pop in the same cycle: `rsp` is already 0 because it uses the pre-pop `count`, so no push occurs. Acceptance resumes the next cycle.
- Pointers wrap modulo DEPTH. DEPTH does not need to be a power of two.
- Ordering is strict FIFO.
- Protocol check, which uses a registered copy of `req`, `rsp` and `req_payload` from the previous cycle:
  - Trigger: the previous cycle had `req && !rsp`.
  - Violation: in the current cycle, `req` is 0 or `req_payload` differs from the captured value.
  - Effect: `protocol_error` sets on the next edge.
  - Clearing: only reset clears it. The check runs whether or not `rsp` is high in the current cycle.
- `done` is registered and asserts when all of the following hold: `EXPECTED != 0`, `accepted >= EXPECTED`, and `count == 0`. It clears if the FIFO becomes non-empty again.

## Timing
- Reset values, applied while `rst` = 0 and asynchronously on assertion:
  - `count` = 0, `out_valid` = 0, `out_payload` = 0.
  - `accepted` = 0, `protocol_error` = 0, `done` = 0.
  - `rsp` = 0, forced combinationally, and the LFSR = SEED.
- Reset mid-operation discards FIFO contents and the protocol-check history. The first cycle after deassertion has no violation history.
- Payload latency: a payload accepted at edge N is visible on `out_payload` with `out_valid` = 1 immediately after edge N, provided the FIFO was empty.
- `count` and `accepted` update at the edge that completes the transfer.
- `done` asserts one cycle after its condition becomes true.
- `rsp` responds in the same cycle to `stall` and to `count`.

## Configuration
- Macro: `SVUTEST_RESPONDER_RANDOM_STALL_EN`.
- Defined:
  - A 16-bit Fibonacci LFSR (taps 16,14,13,11) advances every cycle out of reset.
  - `rand_stall = (lfsr[1:0] == 2'b00)`, giving about 25% pseudo-random backpressure.
  - The sequence is reproducible from SEED.
- Not defined:
  - No LFSR is instantiated and `rand_stall` is 0.
  - `rsp` depends only on occupancy, `stall` and reset.

## Test plan
- Basic flow, macro off, DEPTH=4: drive `req` = 1 with payloads 0x11, 0x22, 0x33 on consecutive cycles and hold `pop` = 0. Required: `rsp` = 1 on all three, `count` = 3, `out_payload` = 0x11, `accepted` = 3.
- Full boundary: push 5 payloads with no pop. Required: `rsp` = 0 on the 5th and `count` stays 4. Then assert `pop` with `req` still high. Required: `rsp` stays 0 in the pop cycle, the 5th payload is accepted the next cycle, and `count` returns to 4.
- Protocol error:
  - Case 1: hold `stall` = 1 and `req` = 1 with 0xA5, then change the payload to 0x5A the next cycle. Required: `protocol_error` = 1 one edge later and it stays set.
  - Case 2: repeat with `req` dropping instead of the payload changing. Required: the same result.
  - Case 3: a stable payload. Required: `protocol_error` stays 0.
- Done: EXPECTED=2, push 2 payloads, then pop 2. Required: `done` = 0 while `count` > 0 and `done` = 1 one cycle after `count` reaches 0. With EXPECTED=0, `done` never asserts.
- Reset mid-operation: with `count` = 3 and `protocol_error` = 1, pull `rst` low between edges. Required: `rsp`, `count`, `accepted`, `protocol_error` and `out_valid` go to 0 immediately, before the next edge.
- Random stall, macro on, SEED=16'hACE1: run 1000 cycles with `req` held high and `pop` held high. Required: every stall cycle matches the reference LFSR model, payload order is preserved, `protocol_error` = 0, and `accepted` equals the count of `rsp`-high cycles.
